// File: rtl/hazard_control_unit.sv
// Hazard control unit for a five-stage in-order pipeline.
// Freezes the whole pipeline while data memory is busy (with a timeout abort),
// flushes IF/ID and ID/EX on a taken branch, and inserts one bubble on a load-use hazard.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined;
// otherwise StallCount and FlushCount are tied to zero.
module hazard_control_unit #(
  parameter int unsigned REG_NUMBER  = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_NUMBER-1:0] ID_EX_rd,
  input  logic [REG_NUMBER-1:0] IF_ID_rs1,
  input  logic [REG_NUMBER-1:0] IF_ID_rs2,
  input  logic                  IF_ID_UseRs2,
  input  logic                  BranchTaken,
  input  logic                  EX_MEM_MemReq,
  input  logic                  MemReady,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Write,
  output logic                  EX_MEM_Write,
  output logic                  MEM_WB_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush,
  output logic                  MemError,
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  // MEM_TIMEOUT is bounded to 255, so eight bits always hold the wait count.
  localparam int unsigned WaitW = 8;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic load_use;
  logic mem_freeze;
  logic mem_timeout;

  // A load in EX feeding a source the ID instruction actually reads; x0 never hazards.
  assign load_use = ID_EX_MemRead && (ID_EX_rd != '0) &&
                    ((ID_EX_rd == IF_ID_rs1) || (IF_ID_UseRs2 && (ID_EX_rd == IF_ID_rs2)));

  // Decode whether memory holds the pipeline this cycle, or the wait has run out.
  always_comb begin
    mem_freeze  = 1'b0;
    mem_timeout = 1'b0;
    unique case (state_q)
      StRun: begin
        mem_freeze = EX_MEM_MemReq && !MemReady;
      end
      StMemWait: begin
        if (!MemReady) begin
          if (wait_q == WaitLast) begin
            mem_timeout = 1'b1;
          end else begin
            mem_freeze = 1'b1;
          end
        end
      end
      default: begin
        mem_freeze  = 1'b0;
        mem_timeout = 1'b0;
      end
    endcase
  end

  // State and wait-counter register; reset aborts any pending wait silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic: enter MEM_WAIT on an unfinished access, leave on ready or timeout.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRun: begin
        wait_d = '0;
        if (EX_MEM_MemReq && !MemReady) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (MemReady || mem_timeout) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  // Output logic: freeze beats branch flush, which beats the load-use bubble.
  // A branch seen during a freeze is simply ignored; EX is held so it reappears on release.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MemError     = mem_timeout;
    if (mem_freeze) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        stall_cyc;
  logic        flush_cyc;

  // A load-use bubble only counts when neither a freeze nor a branch overrides it.
  assign stall_cyc = mem_freeze || (load_use && !BranchTaken);
  assign flush_cyc = BranchTaken && !mem_freeze;

  // Counter next values; both wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cyc ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = flush_cyc ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed cases followed by random stimulus,
// all compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_control_unit;

  localparam int unsigned RegNumber  = 5;
  localparam int unsigned MemTimeout = 16;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 memread;
  logic [RegNumber-1:0] rd, rs1, rs2;
  logic                 use_rs2, branch, memreq, memready;
  logic                 pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, mem_err;
  logic [31:0]          stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .REG_NUMBER (RegNumber),
    .MEM_TIMEOUT(MemTimeout)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID_EX_MemRead(memread),
    .ID_EX_rd     (rd),
    .IF_ID_rs1    (rs1),
    .IF_ID_rs2    (rs2),
    .IF_ID_UseRs2 (use_rs2),
    .BranchTaken  (branch),
    .EX_MEM_MemReq(memreq),
    .MemReady     (memready),
    .PC_Write     (pc_w),
    .IF_ID_Write  (ifid_w),
    .ID_EX_Write  (idex_w),
    .EX_MEM_Write (exmem_w),
    .MEM_WB_Write (memwb_w),
    .IF_ID_Flush  (ifid_f),
    .ID_EX_Flush  (idex_f),
    .MemError     (mem_err),
    .StallCount   (stall_count),
    .FlushCount   (flush_count)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Model state: how many cycles the current memory access has already been frozen.
  int unsigned m_stalled   = 0;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;

  function automatic logic [7:0] ctl_vec();
    return {pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, mem_err};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input bit mr, input logic [RegNumber-1:0] d, s1, s2,
                       input bit u2, br, rq, rdy);
    memread  = mr;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    use_rs2  = u2;
    branch   = br;
    memreq   = rq;
    memready = rdy;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One pipeline cycle: inputs are already applied just after a falling edge.
  // Expected controls come from the priority rules; model advances at the rising edge.
  task automatic cycle(input string tag);
    bit lu, frz, abort;
    logic [7:0] exp_ctl;
    #1;
    lu    = memread && (rd != 0) && (rd == rs1 || (use_rs2 && rd == rs2));
    frz   = 1'b0;
    abort = 1'b0;
    if (m_stalled > 0) begin
      if (!memready) begin
        if (m_stalled >= MemTimeout) abort = 1'b1;
        else frz = 1'b1;
      end
    end else if (memreq && !memready) begin
      frz = 1'b1;
    end
    // {PC, IF/ID, ID/EX, EX/MEM, MEM/WB writes, IF/ID flush, ID/EX flush, MemError}
    if (frz)         exp_ctl = 8'b0000_0000;
    else if (branch) exp_ctl = {7'b11111_11, abort};
    else if (lu)     exp_ctl = {7'b00111_01, abort};
    else             exp_ctl = {7'b11111_00, abort};
    check({tag, "_ctl"}, 64'(ctl_vec()), 64'(exp_ctl));
    check({tag, "_stallcnt"}, 64'(stall_count), PerfEn ? 64'(m_stall_cnt) : 64'd0);
    check({tag, "_flushcnt"}, 64'(flush_count), PerfEn ? 64'(m_flush_cnt) : 64'd0);
    @(posedge clk);
    if (frz || (!branch && lu)) m_stall_cnt++;
    if (!frz && branch) m_flush_cnt++;
    m_stalled = frz ? m_stalled + 1 : 0;
    @(negedge clk);
  endtask

  initial begin
    int unsigned pulses;

    // Reset with idle inputs: normal flow, no error, counters cleared.
    rst_n = 1'b0;
    idle();
    #3;
    check("reset_ctl", 64'(ctl_vec()), 64'b1111_1000);
    check("reset_stallcnt", 64'(stall_count), 64'd0);
    check("reset_flushcnt", 64'(flush_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs1, then the same with rd=x0.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs1");
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("lu_rd0");
    idle();
    cycle("normal");

    // rs2 match only hazards when rs2 is actually read.
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("rs2_unused");
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("rs2_used");

    // Branch overrides a simultaneous load-use.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("branch_over_lu");

    // Memory busy for three cycles, ready on the fourth.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("mem_busy");
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("mem_ready");
    idle();
    cycle("after_mem");
    check("stall_plus3", 64'(stall_count), PerfEn ? 64'd5 : 64'd0);

    // Branch during a freeze is held off until the freeze releases.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle("branch_frozen");
    end
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle("branch_release");

    // Memory never ready: exactly one MemError pulse, on the releasing cycle.
    pulses = 0;
    for (int i = 0; i < MemTimeout + 1; i++) begin
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      if (mem_err) pulses++;
      cycle("timeout_wait");
    end
    idle();
    cycle("after_timeout");
    check("timeout_pulses", 64'(pulses), 64'd1);

    // Asynchronous reset in the middle of a memory wait.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("pre_reset_wait");
    end
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    check("async_reset_ctl", 64'(ctl_vec()), 64'b1111_1000);
    check("async_reset_stallcnt", 64'(stall_count), 64'd0);
    check("async_reset_flushcnt", 64'(flush_count), 64'd0);
    @(posedge clk);
    #1;
    check("reset_hold_ctl", 64'(ctl_vec()), 64'b1111_1000);
    @(negedge clk);
    rst_n       = 1'b1;
    m_stalled   = 0;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
    // With memory not ready but no request, only a lingering wait state would freeze.
    idle();
    cycle("post_reset_run");

    // Random traffic, biased toward register matches and memory stalls.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) != 0));
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter REG_NUMBER, default 5, register index width.
REQ-002 Parameter MEM_TIMEOUT, default 16, maximum MEM_WAIT cycles before abort (range 2..255).
REQ-003 clk  input  1  pipeline clock; single clock domain, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-006 ID_EX_rd  input  REG_NUMBER  destination of instruction in EX.
REQ-007 IF_ID_rs1, IF_ID_rs2  input  REG_NUMBER each  sources of instruction in ID.
REQ-008 IF_ID_UseRs2  input  1  ID instruction reads rs2.
REQ-009 BranchTaken  input  1  EX resolved a taken branch/jump this cycle.
REQ-010 EX_MEM_MemReq  input  1  MEM stage issues a data-memory access.
REQ-011 MemReady  input  1  data memory completes access this cycle.
REQ-012 PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write  output  1 each  stage-register enables.
REQ-013 IF_ID_Flush, ID_EX_Flush  output  1 each  insert bubble into stage register.
REQ-014 MemError  output  1  one-cycle pulse on memory timeout.
REQ-015 StallCount, FlushCount  output  32 each  performance counters (see Configuration).

Function
REQ-016 FSM states SHALL be RUN and MEM_WAIT; state register resets to RUN.
REQ-017 RUN -> MEM_WAIT when EX_MEM_MemReq=1 and MemReady=0; MEM_WAIT -> RUN when MemReady=1 or timeout.
REQ-018 Memory freeze (RUN with EX_MEM_MemReq=1, MemReady=0, or any MEM_WAIT cycle with MemReady=0): all five *_Write=0, both flushes=0.
REQ-019 Wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle; reaching MEM_TIMEOUT-1 forces RUN, pulses MemError for one cycle, and releases the freeze that cycle.
REQ-020 Cycle with MemReady=1 in MEM_WAIT SHALL release the freeze: all *_Write=1 that cycle, branch/load-use evaluated normally.
REQ-021 Load-use hazard = ID_EX_MemRead and ID_EX_rd!=0 and (ID_EX_rd==IF_ID_rs1 or (IF_ID_UseRs2 and ID_EX_rd==IF_ID_rs2)).
REQ-022 Load-use (no freeze, no branch): PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, other writes=1; exactly one bubble per hazard.
REQ-023 BranchTaken (no freeze): IF_ID_Flush=1, ID_EX_Flush=1, all writes=1; overrides load-use same cycle.
REQ-024 Priority: freeze > branch > load-use > normal (all writes=1, flushes=0).
REQ-025 Control outputs SHALL be combinational from state and inputs; no added latency.
REQ-026 BranchTaken asserted during freeze SHALL be ignored and acted on when freeze releases (EX is held, so input persists).

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=RUN, wait counter=0, MemError=0, StallCount=0, FlushCount=0.
REQ-028 While rst_n=0 with idle inputs: all *_Write=1, flushes=0; reset mid-MEM_WAIT aborts wait without MemError.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN defined: StallCount increments each freeze or load-use cycle, FlushCount increments each BranchTaken-flush cycle; both wrap at 2^32-1 -> 0.
REQ-030 Macro HAZARD_PERF_CNT_EN undefined: no counter registers; StallCount and FlushCount tied to 0.

Verification
REQ-031 ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs1=5 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; same with rd=0 -> no stall.
REQ-032 IF_ID_rs2=7, ID_EX_rd=7, IF_ID_UseRs2=0 -> no stall; UseRs2=1 -> stall.
REQ-033 BranchTaken=1 with load-use present -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
REQ-034 EX_MEM_MemReq=1, MemReady low 3 cycles then high -> writes=0 for 3 cycles, 1 on 4th; StallCount +3 (macro on).
REQ-035 MemReady held low, MEM_TIMEOUT=16 -> MemError pulse exactly once, freeze released on that cycle, state RUN next.
REQ-036 rst_n dropped asynchronously mid-MEM_WAIT -> state RUN, counters 0, MemError stays 0.
